serial_subtractor: RTL

Bit-serial, multi-cycle unsigned/two's-complement subtractor computing D = A − B one bit per clock, LSB first, with a ripple borrow held in a flip-flop. It is the inverse-operation companion to the team's gate-level full adder. It sits behind a Start/Done handshake so it can be driven by a lab-level controller or testbench FSM. It trades the area of a WIDTH-bit ripple chain for WIDTH+2 cycles of latency.

---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B, one bit per clock LSB first, behind a Start/Done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output V.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rr;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             bitDiff;
    logic             bitBorrow;
    logic [WIDTH-1:0] rrNext;

    // One-bit full subtractor: returns {borrowOut, difference}.
    function automatic logic [1:0] subBit(input logic a, input logic b, input logic bin);
        logic diff;
        logic bout;
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, diff};
    endfunction

    always_comb begin
        {bitBorrow, bitDiff} = subBit(ra[0], rb[0], br);
        rrNext               = {bitDiff, rr[WIDTH-1:1]};
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic aMsb;
    logic bMsb;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            aMsb <= 1'b0;
            bMsb <= 1'b0;
            V    <= 1'b0;
        end else if (state == IDLE && Start) begin
            aMsb <= A[WIDTH-1];
            bMsb <= B[WIDTH-1];
        end else if (state == SHIFT && cnt == LAST_BIT) begin
            // The last serial bit computed is the result MSB.
            V <= (aMsb != bMsb) && (bitDiff != aMsb);
        end
    end
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        ra    <= A;
                        rb    <= B;
                        rr    <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    rr  <= rrNext;
                    br  <= bitBorrow;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        // Publish the result with the final bit folded in.
                        D     <= rrNext;
                        Bout  <= bitBorrow;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
